// File: rtl/dbus_arbiter_pkg.sv
// Shared D-bus transaction types used by the arbiter and its masters.
package dbus_arbiter_pkg;

    typedef enum logic { READ = 1'b0, WRITE = 1'b1 } ttype_t;

    typedef enum logic [1:0] { BYTE = 2'd0, HALFWORD = 2'd1, WORD = 2'd2 } tsize_t;

endpackage

// File: rtl/dbus_arbiter_arb_rr2.sv
// Two-way round-robin pick: on a tie the master not granted last wins.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Arbitrates two D-bus masters onto one downstream port, one transaction
// outstanding at a time, with a completion timeout.
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_bstart,
    input  logic [ADDR_W-1:0] m0_addr,
    input  ttype_t            m0_ttype,
    input  tsize_t            m0_tsize,
    input  logic [ADDR_W-1:0] m0_wdata,
    output logic [ADDR_W-1:0] m0_rdata,
    output logic              m0_done,
    output logic              m0_err,
    input  logic              m1_bstart,
    input  logic [ADDR_W-1:0] m1_addr,
    input  ttype_t            m1_ttype,
    input  tsize_t            m1_tsize,
    input  logic [ADDR_W-1:0] m1_wdata,
    output logic [ADDR_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic              m1_err,
    output logic              s_bstart,
    output logic [ADDR_W-1:0] s_addr,
    output ttype_t            s_ttype,
    output tsize_t            s_tsize,
    output logic [ADDR_W-1:0] s_wdata,
    input  logic [ADDR_W-1:0] s_rdata,
    input  logic              s_done
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] { IDLE, ISSUE, WAIT } state_t;

    state_t           state, state_nxt;
    logic             p0, p1;
    logic             last;
    logic             owner;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       req, gnt;
    logic             grant, fin_ok, fin_tmo, tmo;
    logic             busy0, busy1;

    // A same-cycle bstart competes immediately instead of waiting a cycle in p0/p1.
    assign req      = {p1 | m1_bstart, p0 | m0_bstart};
    assign busy0    = (state != IDLE) && !owner;
    assign busy1    = (state != IDLE) && owner;
    assign s_bstart = (state == ISSUE);
    // The done pulse is registered, so decide one cycle ahead of the limit.
    assign tmo      = (cnt == CNT_W'(TIMEOUT_CYCLES - 2));

    arb_rr2 u_arb (
        .req  (req),
        .last (last),
        .gnt  (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        fin_ok    = 1'b0;
        fin_tmo   = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (s_done) begin
                    fin_ok    = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo) begin
                    fin_tmo   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p0       <= 1'b0;
            p1       <= 1'b0;
            last     <= 1'b1;
            owner    <= 1'b0;
            cnt      <= '0;
            s_addr   <= '0;
            s_ttype  <= READ;
            s_tsize  <= BYTE;
            s_wdata  <= '0;
            m0_done  <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= '0;
            m1_done  <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= '0;
        end else begin
            m0_done  <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= '0;
            m1_done  <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= '0;

            p0 <= (grant && gnt[0]) ? 1'b0 : (p0 | (m0_bstart & ~busy0));
            p1 <= (grant && gnt[1]) ? 1'b0 : (p1 | (m1_bstart & ~busy1));

            if (grant) begin
                owner   <= gnt[1];
                s_addr  <= gnt[1] ? m1_addr  : m0_addr;
                s_ttype <= gnt[1] ? m1_ttype : m0_ttype;
                s_tsize <= gnt[1] ? m1_tsize : m0_tsize;
                s_wdata <= gnt[1] ? m1_wdata : m0_wdata;
            end

            if (state == ISSUE)     cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 1'b1;

            if (fin_ok || fin_tmo) begin
                last <= owner;
                if (owner) begin
                    m1_done  <= 1'b1;
                    m1_err   <= fin_tmo;
                    m1_rdata <= fin_ok ? s_rdata : '0;
                end else begin
                    m0_done  <= 1'b1;
                    m0_err   <= fin_tmo;
                    m0_rdata <= fin_ok ? s_rdata : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Table-driven plus sequence checks of dbus_arbiter with a downstream
// responder and issue/completion scoreboards.
module tb_dbus_arbiter;
    import dbus_arbiter_pkg::*;

    localparam int TMO = 8;

    typedef struct {
        logic        m;
        ttype_t      tt;
        tsize_t      ts;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;     // 0 = downstream never answers
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        m;
        logic [31:0] rdata;
        logic        err;
    } cmp_t;

    logic        clk, rst;
    logic        m0_bstart, m1_bstart;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    ttype_t      m0_ttype, m1_ttype, s_ttype;
    tsize_t      m0_tsize, m1_tsize, s_tsize;
    logic        m0_done, m1_done, m0_err, m1_err;
    logic        s_bstart, s_done;
    logic [31:0] s_addr, s_wdata, s_rdata;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rsp_cnt = 0;
    logic [31:0] rsp_val = '0;
    bit   stray_pend = 0;
    vec_t iss_q[$];
    cmp_t cmp_q[$];
    int   iss_cyc_h[$];
    int   done_cyc_h[$];
    vec_t vecs[6];

    dbus_arbiter #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_bstart(m0_bstart), .m0_addr(m0_addr), .m0_ttype(m0_ttype), .m0_tsize(m0_tsize),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
        .m1_bstart(m1_bstart), .m1_addr(m1_addr), .m1_ttype(m1_ttype), .m1_tsize(m1_tsize),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .s_bstart(s_bstart), .s_addr(s_addr), .s_ttype(s_ttype), .s_tsize(s_tsize),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_done(s_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {m0_done, m1_done, m0_err, m1_err, s_bstart, m0_rdata, m1_rdata,
                 s_addr, s_wdata, s_ttype, s_tsize}, '0);
    endtask

    task automatic set_req(input vec_t v);
        if (v.m) begin
            m1_bstart = 1'b1; m1_addr = v.addr; m1_ttype = v.tt; m1_tsize = v.ts; m1_wdata = v.wdata;
        end else begin
            m0_bstart = 1'b1; m0_addr = v.addr; m0_ttype = v.tt; m0_tsize = v.ts; m0_wdata = v.wdata;
        end
    endtask

    task automatic push_exp(input vec_t v, input bit want_done);
        cmp_t c;
        iss_q.push_back(v);
        c.m     = v.m;
        c.rdata = (v.lat != 0) ? v.rdata : 32'h0;
        c.err   = (v.lat == 0);
        if (want_done) cmp_q.push_back(c);
    endtask

    task automatic go(input vec_t v);
        set_req(v);
        push_exp(v, 1'b1);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((iss_q.size() != 0 || cmp_q.size() != 0 || rsp_cnt != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk(nm, n < 100, 1'b1);
        iss_q.delete();
        cmp_q.delete();
    endtask

    function automatic vec_t mk(input logic m, input ttype_t tt, input tsize_t ts,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int lat, input logic [31:0] rdata);
        vec_t v;
        v.m = m; v.tt = tt; v.ts = ts; v.addr = addr; v.wdata = wdata; v.lat = lat; v.rdata = rdata;
        return v;
    endfunction

    // Downstream responder plus issue/completion monitor.
    initial begin : mon
        vec_t e;
        cmp_t c;
        logic m;
        s_done  = 1'b0;
        s_rdata = '0;
        forever begin
            @(negedge clk);
            s_done  = 1'b0;
            s_rdata = '0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    s_done  = 1'b1;
                    s_rdata = rsp_val;
                end
            end
            if (stray_pend) begin
                s_done     = 1'b1;
                s_rdata    = 32'hBAD0_BAD0;
                stray_pend = 0;
            end
            if ((m0_err && !m0_done) || (m1_err && !m1_done) ||
                (!m0_done && m0_rdata != 0) || (!m1_done && m1_rdata != 0)) begin
                checks++;
                errors++;
                $display("FAIL quiet_outputs err=%b%b done=%b%b rdata=%0h/%0h required=idle",
                         m0_err, m1_err, m0_done, m1_done, m0_rdata, m1_rdata);
            end
            if (s_bstart) begin
                iss_cyc_h.push_back(cyc);
                if (iss_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue s_addr=%0h required=no issue", s_addr);
                end else begin
                    e = iss_q.pop_front();
                    chk("issue_fields", {s_addr, s_ttype, s_tsize, s_wdata}, {e.addr, e.tt, e.ts, e.wdata});
                    rsp_cnt = e.lat;
                    rsp_val = e.rdata;
                end
            end
            if (m0_done || m1_done) begin
                done_cyc_h.push_back(cyc);
                chk("done_one_hot", m0_done & m1_done, 1'b0);
                if (cmp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done m0_done=%b m1_done=%b required=none", m0_done, m1_done);
                end else begin
                    c = cmp_q.pop_front();
                    m = m1_done;
                    chk("done_resp", m ? {1'b1, m1_rdata, m1_err} : {1'b0, m0_rdata, m0_err},
                        {c.m, c.rdata, c.err});
                    chk("other_quiet", m ? {m0_done, m0_err, m0_rdata} : {m1_done, m1_err, m1_rdata}, '0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t a, b;
        int   t0;
        int   n;
        rst = 1'b1;
        m0_bstart = 0; m0_addr = 0; m0_ttype = READ; m0_tsize = BYTE; m0_wdata = 0;
        m1_bstart = 0; m1_addr = 0; m1_ttype = READ; m1_tsize = BYTE; m1_wdata = 0;

        vecs[0] = mk(1'b0, READ,  WORD,     32'h2000_0010, 32'h0000_0000, 1, 32'hDEAD_BEEF);
        vecs[1] = mk(1'b1, WRITE, BYTE,     32'h1000_0004, 32'h0000_00A5, 2, 32'h1234_5678);
        vecs[2] = mk(1'b0, WRITE, HALFWORD, 32'h3000_0002, 32'h0000_BEEF, 5, 32'h0BAD_F00D);
        vecs[3] = mk(1'b1, READ,  WORD,     32'h4000_0000, 32'h0,         0, 32'hFFFF_FFFF);
        vecs[4] = mk(1'b0, READ,  BYTE,     32'hFFFF_FFFF, 32'h0,         TMO - 1, 32'hCAFE_0001);
        vecs[5] = mk(1'b1, READ,  HALFWORD, 32'h0000_0000, 32'h0,         6, 32'h0000_8001);

        repeat (3) @(negedge clk);
        chk_zero("reset_state");
        rst = 1'b0;

        // stray s_done while idle
        stray_pend = 1;
        repeat (3) @(negedge clk);
        chk_zero("stray_idle");

        for (int i = 0; i < 6; i++) begin
            iss_cyc_h.delete();
            done_cyc_h.delete();
            t0 = cyc;
            go(vecs[i]);
            @(negedge clk);
            m0_bstart = 0; m1_bstart = 0;
            drain("vec_drain");
            chk("vec_events", {iss_cyc_h.size(), done_cyc_h.size()}, {32'd1, 32'd1});
            if (iss_cyc_h.size() == 1 && done_cyc_h.size() == 1) begin
                chk("vec_issue_lat", iss_cyc_h[0] - t0, 1);
                chk("vec_done_lat", done_cyc_h[0] - iss_cyc_h[0],
                    vecs[i].lat != 0 ? vecs[i].lat + 1 : TMO);
            end
        end

        // tie: m0 first; m0 re-requests in its done cycle and now loses to m1
        a = mk(1'b0, READ, WORD, 32'h2000_0A00, 32'h0, 1, 32'hA0A0_0001);
        b = mk(1'b1, READ, WORD, 32'h2000_0B00, 32'h0, 1, 32'hB0B0_0002);
        go(a);
        go(b);
        @(negedge clk);
        m0_bstart = 0; m1_bstart = 0;
        n = 0;
        while (!m0_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tie_m0_done_seen", m0_done, 1'b1);
        go(mk(1'b0, WRITE, WORD, 32'h2000_0C00, 32'h1111_2222, 2, 32'hC0C0_0003));
        @(negedge clk);
        m0_bstart = 0;
        drain("tie_drain");

        // m1 arrives (and repeats bstart) while m0 is in flight
        iss_cyc_h.delete();
        done_cyc_h.delete();
        go(mk(1'b0, READ, WORD, 32'h2000_0100, 32'h0, 4, 32'h5555_AAAA));
        @(negedge clk);
        m0_bstart = 0;
        @(negedge clk);
        go(mk(1'b1, WRITE, BYTE, 32'h1000_0004, 32'h0000_00A5, 1, 32'h0000_0077));
        @(negedge clk);
        @(negedge clk);
        m1_bstart = 0;
        chk("pending_hold", {s_addr, s_wdata}, {32'h2000_0100, 32'h0});
        drain("pend_drain");
        if (iss_cyc_h.size() == 2 && done_cyc_h.size() == 2)
            chk("pend_back_to_back", iss_cyc_h[1] - done_cyc_h[0], 1);
        else
            chk("pend_events", {iss_cyc_h.size(), done_cyc_h.size()}, {32'd2, 32'd2});

        // timeout, then the pending master issues
        iss_cyc_h.delete();
        done_cyc_h.delete();
        go(mk(1'b0, READ, WORD, 32'h2000_0200, 32'h0, 0, 32'h0));
        @(negedge clk);
        m0_bstart = 0;
        @(negedge clk);
        go(mk(1'b1, READ, WORD, 32'h3000_0300, 32'h0, 1, 32'h3333_0300));
        @(negedge clk);
        m1_bstart = 0;
        drain("tmo_drain");
        if (iss_cyc_h.size() == 2 && done_cyc_h.size() == 2) begin
            chk("tmo_lat", done_cyc_h[0] - iss_cyc_h[0], TMO);
            chk("tmo_next_issue", iss_cyc_h[1] - done_cyc_h[0], 1);
        end else
            chk("tmo_events", {iss_cyc_h.size(), done_cyc_h.size()}, {32'd2, 32'd2});

        // reset while waiting, then a late s_done
        push_exp(mk(1'b0, READ, WORD, 32'h2000_0300, 32'h0, 0, 32'h0), 1'b0);
        set_req(mk(1'b0, READ, WORD, 32'h2000_0300, 32'h0, 0, 32'h0));
        @(negedge clk);
        m0_bstart = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stray_pend = 1;
        chk_zero("rst_outputs");
        repeat (4) @(negedge clk);
        chk_zero("rst_after_sdone");
        chk("rst_issue_seen", iss_q.size(), 0);

        // pointer back at reset value: m0 wins the tie
        go(mk(1'b0, READ, WORD, 32'h2000_0D00, 32'h0, 1, 32'hD0D0_0004));
        go(mk(1'b1, READ, WORD, 32'h2000_0E00, 32'h0, 3, 32'hE0E0_0005));
        @(negedge clk);
        m0_bstart = 0; m1_bstart = 0;
        drain("rst_tie_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
